// File: rtl/delay_gate_multi_if.sv
// Bus bundle for delay_gate_multi: CE, per-channel requests/modes, delay load port and qualified outputs.
interface delay_gate_multi_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  logic          CE;
  logic [CH-1:0] Delin;
  logic [CH-1:0] Mode;
  logic          DelayLd;
  logic [W-1:0]  DelayIn;
  logic [CH-1:0] DelCE;
  logic [CH-1:0] Reached;
  logic [W-1:0]  DelayCur;

  modport master (
    output CE, Delin, Mode, DelayLd, DelayIn,
    input  DelCE, Reached, DelayCur
  );

  modport slave (
    input  CE, Delin, Mode, DelayLd, DelayIn,
    output DelCE, Reached, DelayCur
  );
endinterface

// File: rtl/delay_gate_multi.sv
// Multi-channel CE qualification gate with a shared runtime-programmable settle delay.
// Optional macro DELAY_GATE_REARM_EN: pulse-mode channels re-arm after each pulse while Delin stays high.
module delay_gate_multi #(
  parameter int CH        = 4,
  parameter int W         = 8,
  parameter int DELAY_RST = 2
) (
  input  logic               CLK,
  input  logic               RST,
  delay_gate_multi_if.slave  bus
);

  logic [W-1:0]         dly_q, dly_d;
  logic [CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]        fired_q, fired_d;
  logic [CH-1:0]        reach;
  logic [CH-1:0]        del_ce;

  // Qualification uses >= so lowering the delay below a live count passes immediately.
  always_comb begin
    reach  = '0;
    del_ce = '0;
    for (int i = 0; i < CH; i++) begin
      reach[i]  = bus.Delin[i] & (cnt_q[i] >= dly_q);
      del_ce[i] = bus.CE & reach[i] & ~RST & (~bus.Mode[i] | ~fired_q[i]);
    end
  end

  assign bus.DelCE    = del_ce;
  assign bus.Reached  = reach & ~{CH{RST}};
  assign bus.DelayCur = dly_q;

  always_comb begin
    dly_d   = bus.DelayLd ? bus.DelayIn : dly_q;
    cnt_d   = cnt_q;
    fired_d = fired_q;
    for (int i = 0; i < CH; i++) begin
      if (bus.CE) begin
        if (!bus.Delin[i]) begin
          cnt_d[i]   = '0;
          fired_d[i] = 1'b0;
        end else if (cnt_q[i] < dly_q) begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
      end
      if (del_ce[i]) begin
        fired_d[i] = 1'b1;
      end
`ifdef DELAY_GATE_REARM_EN
      // A pulse-mode channel restarts its settle window after every pulse.
      if (del_ce[i] && bus.Mode[i]) begin
        cnt_d[i]   = '0;
        fired_d[i] = 1'b0;
      end
`else
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dly_q   <= W'(DELAY_RST);
      cnt_q   <= '0;
      fired_q <= '0;
    end else begin
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: tb/tb_delay_gate_multi.sv
// Directed self-checking bench for delay_gate_multi; honours DELAY_GATE_REARM_EN when defined.
module tb_delay_gate_multi;

  localparam int CH = 4;
  localparam int W  = 8;
`ifdef DELAY_GATE_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  delay_gate_multi_if #(.CH(CH), .W(W)) bus ();

  delay_gate_multi #(.CH(CH), .W(W), .DELAY_RST(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One CE cycle with every request low clears all counters and fired flags.
  task automatic clear_channels();
    bus.CE      = 1'b1;
    bus.Delin   = '0;
    bus.Mode    = '0;
    bus.DelayLd = 1'b0;
    next_cycle();
  endtask

  task automatic load_delay(input logic [W-1:0] v);
    bus.DelayLd = 1'b1;
    bus.DelayIn = v;
    next_cycle();
    bus.DelayLd = 1'b0;
  endtask

  task automatic test_reset();
    logic exp;
    RST         = 1'b1;
    bus.CE      = 1'b1;
    bus.Delin   = '0;
    bus.Mode    = '0;
    bus.DelayLd = 1'b0;
    bus.DelayIn = '0;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.DelayCur !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL reset_delaycur: got %0d expected 2", bus.DelayCur);
    end
    n_checks++;
    if (bus.DelCE !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_delce: got %b expected 0000", bus.DelCE);
    end
    @(posedge CLK);
    #1;
    for (int c = 0; c < 5; c++) begin
      bus.Delin[0] = 1'b1;
      exp = (c >= 2);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[0] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t1_delce c=%0d: got %0b expected %0b", c, bus.DelCE[0], exp);
      end
      n_checks++;
      if (bus.Reached[0] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t1_reached c=%0d: got %0b expected %0b", c, bus.Reached[0], exp);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_ce_pattern();
    logic exp;
    clear_channels();
    load_delay(8'd3);
    n_checks++;
    if (bus.DelayCur !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL t2_delaycur: got %0d expected 3", bus.DelayCur);
    end
    for (int k = 0; k < 20; k++) begin
      bus.CE       = (k % 2 == 0);
      bus.Delin[0] = (k != 10);
      exp = (k % 2 == 0) && ((k >= 6 && k < 10) || k >= 18);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[0] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t2_delce k=%0d: got %0b expected %0b", k, bus.DelCE[0], exp);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_pulse();
    logic exp;
    int   pulses;
    clear_channels();
    load_delay(8'd4);
    bus.Mode[1] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      bus.Delin[1] = (c != 12);
      if (c < 12)
        exp = (c == 4) || (REARM && c == 9);
      else
        exp = (c == 17);
      @(negedge CLK);
      if (bus.DelCE[1]) pulses++;
      n_checks++;
      if (bus.DelCE[1] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t3_pulse c=%0d: got %0b expected %0b", c, bus.DelCE[1], exp);
      end
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (pulses != (REARM ? 3 : 2)) begin
      n_fail++;
      $display("[TB] FAIL t3_pulse_count: got %0d expected %0d", pulses, REARM ? 3 : 2);
    end
    // Level pass-through, then switching to pulse mode must stay silent.
    clear_channels();
    for (int c = 0; c < 10; c++) begin
      bus.Delin[1] = 1'b1;
      bus.Mode[1]  = (c >= 6 && c < 9);
      exp = (c >= 4) && !(c >= 6 && c < 9);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[1] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t3_modeswitch c=%0d: got %0b expected %0b", c, bus.DelCE[1], exp);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_delay_change();
    logic exp;
    clear_channels();
    load_delay(8'd7);
    for (int c = 0; c < 14; c++) begin
      bus.Delin[2] = 1'b1;
      bus.DelayLd  = (c == 9 || c == 13);
      bus.DelayIn  = (c == 9) ? 8'd3 : 8'd0;
      exp = (c >= 7);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[2] !== exp || bus.Reached[2] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t4_saturated c=%0d: got delce=%0b reached=%0b expected %0b",
                 c, bus.DelCE[2], bus.Reached[2], exp);
      end
      if (c == 12) begin
        n_checks++;
        if (bus.DelayCur !== 8'd3) begin
          n_fail++;
          $display("[TB] FAIL t4_delaycur3: got %0d expected 3", bus.DelayCur);
        end
      end
      @(posedge CLK);
      #1;
    end
    bus.DelayLd = 1'b0;
    n_checks++;
    if (bus.DelayCur !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL t4_delaycur0: got %0d expected 0", bus.DelayCur);
    end
    // Zero delay: a freshly asserted level channel follows CE & Delin at once.
    for (int c = 0; c < 3; c++) begin
      bus.Delin[3] = 1'b1;
      bus.CE       = (c != 1);
      exp = (c != 1);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[3] !== exp || bus.Reached[3] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL t4_zero_delay c=%0d: got delce=%0b reached=%0b expected %0b/1",
                 c, bus.DelCE[3], bus.Reached[3], exp);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_mid_reset();
    logic exp;
    clear_channels();
    load_delay(8'd5);
    for (int c = 0; c < 11; c++) begin
      bus.Delin[0] = 1'b1;
      RST = (c == 3 || c == 7);
      exp = (c == 6 || c == 10);
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE[0] !== exp || bus.Reached[0] !== exp) begin
        n_fail++;
        $display("[TB] FAIL t5_reset c=%0d: got delce=%0b reached=%0b expected %0b",
                 c, bus.DelCE[0], bus.Reached[0], exp);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.DelayCur !== 8'd2) begin
          n_fail++;
          $display("[TB] FAIL t5_delaycur: got %0d expected 2", bus.DelayCur);
        end
      end
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
  endtask

  task automatic test_staggered();
    logic [CH-1:0] exp_ce, exp_rch;
    clear_channels();
    load_delay(8'd2);
    for (int c = 0; c < 9; c++) begin
      bus.Mode = 4'b1010;
      exp_ce   = '0;
      exp_rch  = '0;
      for (int i = 0; i < CH; i++) begin
        bus.Delin[i] = (c >= i);
        if (bus.Mode[i]) begin
          if (REARM) begin
            exp_ce[i]  = (c >= i + 2) && ((c - i - 2) % 3 == 0);
            exp_rch[i] = exp_ce[i];
          end else begin
            exp_ce[i]  = (c == i + 2);
            exp_rch[i] = (c >= i + 2);
          end
        end else begin
          exp_ce[i]  = (c >= i + 2);
          exp_rch[i] = (c >= i + 2);
        end
      end
      @(negedge CLK);
      n_checks++;
      if (bus.DelCE !== exp_ce || bus.Reached !== exp_rch) begin
        n_fail++;
        $display("[TB] FAIL t6_staggered c=%0d: got delce=%b reached=%b expected %b/%b",
                 c, bus.DelCE, bus.Reached, exp_ce, exp_rch);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    $display("[TB] starting delay_gate_multi bench (rearm=%0b)", REARM);
    test_reset();
    test_ce_pattern();
    test_pulse();
    test_delay_change();
    test_mid_reset();
    test_staggered();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_gate_multi.md
Name: delay_gate_multi

Overview:
- Multi-channel, runtime-programmable enable-qualification gate for the DDS core.
- Each channel counts consecutive CE-qualified cycles of its request input. Once that count reaches a shared delay value, the channel passes CE through.
- Pass-through is either continuous (level mode) or a single CE cycle (pulse mode).
- Sits between control/sequencing logic and the phase-accumulator/output CE domains. Gates channel start-up after a programmable settle time.

Parameters:
- CH, 4, number of independent channels.
- W, 8, width of delay register and per-channel counters.
- DELAY_RST, 2, delay value loaded at reset; must be < 2^W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  global clock enable; counting advances only on CE cycles.
- Delin  in  CH  per-channel request; held high to qualify.
- Mode  in  CH  per-channel mode: 0 = level, 1 = pulse.
- DelayLd  in  1  load strobe for DelayIn; independent of CE.
- DelayIn  in  W  new delay value.
- DelCE  out  CH  qualified per-channel enable.
- Reached  out  CH  channel counter has reached delay while Delin high.
- DelayCur  out  W  currently active delay value.

Behaviour:
- Reset (RST high at an edge): dly <= DELAY_RST; all cnt[i] <= 0; all fired[i] <= 0. While RST is high, DelCE and Reached are forced to 0. DelayCur shows DELAY_RST from the first post-reset cycle.
- Delay register: DelayLd high at an edge loads DelayIn into dly. The new value is used from the next cycle. On an edge where DelayLd and CE are both active, counter updates compare against the old dly.
- Per-channel counter update, only when CE = 1:
  - Delin[i] = 0: cnt[i] <= 0, fired[i] <= 0.
  - Delin[i] = 1 and cnt[i] < dly: cnt[i] <= cnt[i] + 1.
  - Otherwise: hold, i.e. saturate at dly.
- When CE = 0, cnt and fired hold regardless of Delin.
- reach[i] = Delin[i] & (cnt[i] >= dly). The >= comparison covers dly being lowered below a live count: such a channel counts as reached immediately.
- Reached[i] = reach[i] & ~RST. Combinational.
- Level mode: DelCE[i] = CE & reach[i] & ~RST. Combinational, zero added latency.
  - With dly = D and CE held high, Delin rising at cycle 0: DelCE high from cycle D onward.
  - D = 0: DelCE = CE & Delin.
- Pulse mode: DelCE[i] = CE & reach[i] & ~fired[i] & ~RST.
  - At any edge where DelCE[i] = 1 (either mode), fired[i] <= 1.
  - Result: one DelCE cycle per Delin assertion.
  - Switching level -> pulse after the channel has already passed CE produces no pulse until Delin drops.
- Mode changes take effect combinationally in the same cycle.
- Channels are fully independent except for the shared dly.
- Arithmetic is unsigned W-bit. The counter never wraps because it saturates at dly ≤ 2^W-1.

Optional Feature:
- Macro: DELAY_GATE_REARM_EN.
- Defined: in pulse mode, an edge with DelCE[i] = 1 clears cnt[i] to 0 and leaves fired[i] = 0.
  - With Delin held and CE continuous, pulses repeat every D+1 CE cycles.
  - D = 0 gives a pulse every CE cycle.
  - Level mode is unchanged.
- Undefined: single pulse per Delin assertion, as described in Behaviour.

Test Plan:
1. Reset, ch0 level, Delin[0] = 1 from cycle 0, CE = 1 -> DelCE[0] = 0 at cycles 0-1, 1 from cycle 2; Reached[0] matches; DelayCur = 2.
2. DelayLd with DelayIn = 3, ch0 level, CE pattern 1,0,1,0,... -> DelCE[0] first high on the 4th CE-high cycle, low on every CE-low cycle; Delin drop for one CE cycle restarts the count.
3. ch1 pulse, dly = 4, Delin[1] held 12 cycles, CE = 1 -> exactly one DelCE[1] pulse at cycle 4. Drop Delin one cycle, reassert -> one pulse 4 cycles after reassertion. With DELAY_GATE_REARM_EN: pulses at cycles 4, 9.
4. dly = 7, ch2 counter saturated at 7, then load 3 -> Reached[2] stays 1, DelCE[2] uninterrupted. Load 0 -> level DelCE = CE & Delin on a freshly asserted channel in its first cycle.
5. dly = 5, ch0 counting, RST pulsed for one cycle at count 3 -> DelCE = 0 during RST, dly back to 2, ch0 needs 2 full CE cycles after release.
6. All 4 channels, staggered Delin rises at cycles 0/1/2/3, dly = 2, mixed modes -> each channel's DelCE starts exactly 2 cycles after its own rise; no cross-channel interaction.
